// File: rtl/dynamic_flush_controller.sv
// Squashes younger instructions after an unconditional transfer or branch mispredict.
// An optional bimodal branch history table supplies fetch-time predictions.
module dynamic_flush_controller #(
   parameter int unsigned FLUSH_DEPTH    = 3,
   parameter int unsigned BHT_INDEX_BITS = 4,
   parameter bit          DYNAMIC        = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [15:0] fetch_pc,
   output logic        predict_taken,
   input  logic        branch_valid,
   input  logic [15:0] branch_pc,
   input  logic        branch_taken,
   input  logic        branch_predicted,
   input  logic        is_j_in,
   input  logic        is_jsr_in,
   input  logic        is_trap_in,
   input  logic        load_regfile_in,
   input  logic        mem_write_in,
   input  logic        mem_read_in,
   output logic        load_regfile_out,
   output logic        mem_write_out,
   output logic        mem_read_out,
   output logic        branch_enable_out,
   output logic        is_j_out,
   output logic        is_jsr_out,
   output logic        is_trap_out,
   output logic        redirect_fallthrough,
   output logic        flushed,
   output logic [1:0]  forwarding_mask,
   output logic [15:0] mispredict_count
);

   typedef enum logic [1:0] {StIdle, StFlush, StPost} state_e;

   localparam logic [2:0] DepthC = 3'(FLUSH_DEPTH);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] mispredict_count_q, mispredict_count_d;

   logic mispredict, uncond, flush_event;
   logic unused_pc_bits;

   assign mispredict  = branch_valid & (branch_taken != branch_predicted);
   assign uncond      = is_j_in | is_jsr_in | is_trap_in;
   assign flush_event = (mispredict | uncond) & ~stall;

   // Only the index bits of the PCs reach the table.
   assign unused_pc_bits = ^{fetch_pc, branch_pc};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= StIdle;
         cnt_q              <= 3'd0;
         mispredict_count_q <= 16'd0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      cnt_d              = cnt_q;
      mispredict_count_d = mispredict_count_q;
      unique case (state_q)
         StIdle: begin
            if (flush_event) begin
               state_d = StFlush;
               cnt_d   = 3'd1;
            end
         end
         StFlush: begin
            if (!stall) begin
               if (cnt_q == DepthC) begin
                  state_d = StPost;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         StPost: begin
            if (flush_event) begin
               state_d = StFlush;
               cnt_d   = 3'd1;
            end else if (!stall) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 3'd0;
         end
      endcase
      // Events seen while squashing belong to squashed instructions.
      if (flush_event && mispredict && (state_q != StFlush) &&
          (mispredict_count_q != 16'hFFFF)) begin
         mispredict_count_d = mispredict_count_q + 16'd1;
      end
   end

   always_comb begin
      load_regfile_out     = load_regfile_in;
      mem_write_out        = mem_write_in;
      mem_read_out         = mem_read_in;
      branch_enable_out    = branch_taken;
      is_j_out             = is_j_in;
      is_jsr_out           = is_jsr_in;
      is_trap_out          = is_trap_in;
      redirect_fallthrough = branch_valid & branch_predicted & ~branch_taken;
      flushed              = 1'b0;
      forwarding_mask      = 2'b11;
      unique case (state_q)
         StFlush: begin
            load_regfile_out     = 1'b0;
            mem_write_out        = 1'b0;
            mem_read_out         = 1'b0;
            branch_enable_out    = 1'b0;
            is_j_out             = 1'b0;
            is_jsr_out           = 1'b0;
            is_trap_out          = 1'b0;
            redirect_fallthrough = 1'b0;
            flushed              = 1'b1;
            forwarding_mask      = (cnt_q == 3'd1) ? 2'b00 : 2'b11;
         end
         StPost:  forwarding_mask = 2'b10;
         default: forwarding_mask = 2'b11;
      endcase
   end

   assign mispredict_count = mispredict_count_q;

   if (DYNAMIC) begin : g_bht
      localparam int unsigned Entries = 2 ** BHT_INDEX_BITS;

      logic [1:0]                bht_q [Entries];
      logic [1:0]                bht_d;
      logic [BHT_INDEX_BITS-1:0] fetch_idx, upd_idx;
      logic                      bht_upd;

      assign fetch_idx = fetch_pc[BHT_INDEX_BITS:1];
      assign upd_idx   = branch_pc[BHT_INDEX_BITS:1];
      assign bht_upd   = branch_valid & ~stall & (state_q != StFlush);

      always_comb begin
         bht_d = bht_q[upd_idx];
         if (branch_taken && (bht_q[upd_idx] != 2'b11)) begin
            bht_d = bht_q[upd_idx] + 2'b01;
         end else if (!branch_taken && (bht_q[upd_idx] != 2'b00)) begin
            bht_d = bht_q[upd_idx] - 2'b01;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < Entries; i++) begin
               bht_q[i] <= 2'b01;
            end
         end else if (bht_upd) begin
            bht_q[upd_idx] <= bht_d;
         end
      end

      // Reads the pre-update counter when lookup and update collide.
      assign predict_taken = bht_q[fetch_idx][1];
   end else begin : g_static
      assign predict_taken = 1'b0;
   end

endmodule

// File: tb/tb_dynamic_flush_controller.sv
// Directed bench: a static depth-3 instance and a dynamic depth-5 instance share stimulus.
module tb_dynamic_flush_controller;

   logic        clk = 1'b0;
   logic        reset, stall, branch_valid, branch_taken, branch_predicted;
   logic        is_j_in, is_jsr_in, is_trap_in, load_regfile_in, mem_write_in, mem_read_in;
   logic [15:0] fetch_pc, branch_pc;

   logic        s_pred, s_load, s_mw, s_mr, s_ben, s_j, s_jsr, s_trap, s_redir, s_flushed;
   logic [1:0]  s_mask;
   logic [15:0] s_count;
   logic        d_pred, d_load, d_mw, d_mr, d_ben, d_j, d_jsr, d_trap, d_redir, d_flushed;
   logic [1:0]  d_mask;
   logic [15:0] d_count;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dynamic_flush_controller #(.FLUSH_DEPTH(3), .BHT_INDEX_BITS(4), .DYNAMIC(1'b0)) u_s (
      .clk(clk), .reset(reset), .stall(stall), .fetch_pc(fetch_pc), .predict_taken(s_pred),
      .branch_valid(branch_valid), .branch_pc(branch_pc), .branch_taken(branch_taken),
      .branch_predicted(branch_predicted), .is_j_in(is_j_in), .is_jsr_in(is_jsr_in),
      .is_trap_in(is_trap_in), .load_regfile_in(load_regfile_in), .mem_write_in(mem_write_in),
      .mem_read_in(mem_read_in), .load_regfile_out(s_load), .mem_write_out(s_mw),
      .mem_read_out(s_mr), .branch_enable_out(s_ben), .is_j_out(s_j), .is_jsr_out(s_jsr),
      .is_trap_out(s_trap), .redirect_fallthrough(s_redir), .flushed(s_flushed),
      .forwarding_mask(s_mask), .mispredict_count(s_count)
   );

   dynamic_flush_controller #(.FLUSH_DEPTH(5), .BHT_INDEX_BITS(4), .DYNAMIC(1'b1)) u_d (
      .clk(clk), .reset(reset), .stall(stall), .fetch_pc(fetch_pc), .predict_taken(d_pred),
      .branch_valid(branch_valid), .branch_pc(branch_pc), .branch_taken(branch_taken),
      .branch_predicted(branch_predicted), .is_j_in(is_j_in), .is_jsr_in(is_jsr_in),
      .is_trap_in(is_trap_in), .load_regfile_in(load_regfile_in), .mem_write_in(mem_write_in),
      .mem_read_in(mem_read_in), .load_regfile_out(d_load), .mem_write_out(d_mw),
      .mem_read_out(d_mr), .branch_enable_out(d_ben), .is_j_out(d_j), .is_jsr_out(d_jsr),
      .is_trap_out(d_trap), .redirect_fallthrough(d_redir), .flushed(d_flushed),
      .forwarding_mask(d_mask), .mispredict_count(d_count)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_taken = 1'b0;
      branch_predicted = 1'b0; is_j_in = 1'b0; is_jsr_in = 1'b0; is_trap_in = 1'b0;
      load_regfile_in = 1'b1; mem_write_in = 1'b1; mem_read_in = 1'b1;
      fetch_pc = 16'h3000; branch_pc = 16'h3000;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("s_rst_flushed", 16'(s_flushed), 16'd0);
      chk("s_rst_mask", 16'(s_mask), 16'd3);
      chk("s_rst_count", s_count, 16'd0);
      chk("s_rst_load", 16'(s_load), 16'd1);
      chk("s_rst_pred", 16'(s_pred), 16'd0);

      // Static taken branch: three squash cycles, then one POST cycle.
      branch_valid = 1'b1; branch_taken = 1'b1;
      #1;
      chk("s_ev_flushed", 16'(s_flushed), 16'd0);
      chk("s_ev_ben", 16'(s_ben), 16'd1);
      chk("s_ev_redir", 16'(s_redir), 16'd0);
      tick();
      branch_valid = 1'b0; branch_taken = 1'b0;
      #1;
      chk("s_f1_flushed", 16'(s_flushed), 16'd1);
      chk("s_f1_mask", 16'(s_mask), 16'd0);
      chk("s_f1_load", 16'(s_load), 16'd0);
      chk("s_f1_mw", 16'(s_mw), 16'd0);
      chk("s_f1_mr", 16'(s_mr), 16'd0);
      chk("s_f1_count", s_count, 16'd1);
      tick();
      chk("s_f2_flushed", 16'(s_flushed), 16'd1);
      chk("s_f2_mask", 16'(s_mask), 16'd3);
      tick();
      chk("s_f3_flushed", 16'(s_flushed), 16'd1);
      chk("s_f3_mask", 16'(s_mask), 16'd3);
      tick();
      chk("s_post_flushed", 16'(s_flushed), 16'd0);
      chk("s_post_mask", 16'(s_mask), 16'd2);
      chk("s_post_load", 16'(s_load), 16'd1);
      tick();
      chk("s_idle_mask", 16'(s_mask), 16'd3);
      chk("s_idle_count", s_count, 16'd1);

      // Stall in the second squash cycle holds the counter.
      branch_valid = 1'b1; branch_taken = 1'b1;
      tick();
      branch_valid = 1'b0; branch_taken = 1'b0;
      tick();
      stall = 1'b1;
      #1;
      chk("s_st_flushed", 16'(s_flushed), 16'd1);
      chk("s_st_mask", 16'(s_mask), 16'd3);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("s_st_hold", 16'(s_flushed), 16'd1);
      end
      stall = 1'b0;
      tick();
      chk("s_st_f3_flushed", 16'(s_flushed), 16'd1);
      tick();
      chk("s_st_post_flushed", 16'(s_flushed), 16'd0);
      chk("s_st_post_mask", 16'(s_mask), 16'd2);
      chk("s_st_count", s_count, 16'd2);

      // Trap in POST re-enters the flush without counting.
      is_trap_in = 1'b1;
      #1;
      chk("s_trap_pass", 16'(s_trap), 16'd1);
      tick();
      chk("s_trap_flushed", 16'(s_flushed), 16'd1);
      chk("s_trap_mask", 16'(s_mask), 16'd0);
      chk("s_trap_gated", 16'(s_trap), 16'd0);
      chk("s_trap_count", s_count, 16'd2);
      is_trap_in = 1'b0;

      // Dynamic instance: train the counter at 0x3006 (index 3).
      reset = 1'b1;
      tick();
      reset = 1'b0;
      fetch_pc = 16'h3006; branch_pc = 16'h3006;
      branch_valid = 1'b1; branch_taken = 1'b1; branch_predicted = 1'b0;
      #1;
      chk("d_pred_init", 16'(d_pred), 16'd0);
      chk("d_rst_count", d_count, 16'd0);
      tick();
      branch_valid = 1'b0; branch_taken = 1'b0;
      #1;
      chk("d_f1_flushed", 16'(d_flushed), 16'd1);
      chk("d_pred_10", 16'(d_pred), 16'd1);
      chk("d_f1_count", d_count, 16'd1);
      repeat (4) tick();
      chk("d_f5_flushed", 16'(d_flushed), 16'd1);
      tick();
      chk("d_post_mask", 16'(d_mask), 16'd2);
      tick();
      chk("d_idle_mask", 16'(d_mask), 16'd3);
      chk("d_idle_flushed", 16'(d_flushed), 16'd0);

      branch_valid = 1'b1; branch_taken = 1'b1; branch_predicted = 1'b1;
      #1;
      chk("d_hit_redir", 16'(d_redir), 16'd0);
      tick();
      chk("d_hit_flushed", 16'(d_flushed), 16'd0);
      chk("d_hit_count", d_count, 16'd1);
      chk("d_pred_11", 16'(d_pred), 16'd1);
      tick();
      chk("d_hit2_flushed", 16'(d_flushed), 16'd0);
      chk("d_hit2_count", d_count, 16'd1);

      // Predicted taken, resolved not taken: redirect and decrement 11 -> 10.
      branch_taken = 1'b0;
      #1;
      chk("d_miss_redir", 16'(d_redir), 16'd1);
      chk("d_miss_flushed", 16'(d_flushed), 16'd0);
      tick();
      branch_valid = 1'b0; branch_predicted = 1'b0;
      #1;
      chk("d_miss_f1", 16'(d_flushed), 16'd1);
      chk("d_miss_mask", 16'(d_mask), 16'd0);
      chk("d_miss_count", d_count, 16'd2);
      chk("d_pred_dec", 16'(d_pred), 16'd1);
      chk("d_miss_redir_sq", 16'(d_redir), 16'd0);

      // Reset at cnt==3 of a depth-5 flush.
      tick();
      tick();
      chk("d_c3_flushed", 16'(d_flushed), 16'd1);
      chk("d_c3_mask", 16'(d_mask), 16'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("d_rr_flushed", 16'(d_flushed), 16'd0);
      chk("d_rr_mask", 16'(d_mask), 16'd3);
      chk("d_rr_load", 16'(d_load), 16'd1);
      chk("d_rr_count", d_count, 16'd0);
      chk("d_rr_pred", 16'(d_pred), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dynamic_flush_controller.md
Name: dynamic_flush_controller

Overview:
- Parametrised successor to the fixed three-bubble static-not-taken flush controller in the LC-3b pipeline.
- Sits between the MEM-stage control signals and the register-file, memory and branch-unit enables.
- On an unconditional control transfer (JMP/RET, JSR/JSRR, TRAP) or a conditional-branch mispredict, it squashes a configurable number of younger instructions, then masks forwarding for one cycle.
- Adds an optional bimodal branch history table (BHT) that supplies a taken/not-taken prediction to fetch. In dynamic mode, correctly predicted branches cost no flush.

Parameters:
- FLUSH_DEPTH, 3: number of squash cycles per flush event; legal range 1..7.
- BHT_INDEX_BITS, 4: BHT has 2^BHT_INDEX_BITS entries of 2-bit counters.
- DYNAMIC, 0: 0 = static not-taken (prediction always 0); 1 = BHT prediction.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; freezes state and BHT updates
- fetch_pc  in  16  PC being fetched (lc3b_word)
- predict_taken  out  1  prediction for fetch_pc (combinational)
- branch_valid  in  1  MEM-stage instruction is a conditional branch
- branch_pc  in  16  PC of that branch
- branch_taken  in  1  resolved outcome (branch_enable)
- branch_predicted  in  1  prediction carried down the pipe with the branch
- is_j_in / is_jsr_in / is_trap_in  in  1 each  unconditional transfer in MEM
- load_regfile_in, mem_write_in, mem_read_in  in  1 each  raw enables
- load_regfile_out, mem_write_out, mem_read_out  out  1 each  gated enables
- branch_enable_out, is_j_out, is_jsr_out, is_trap_out  out  1 each  gated transfer controls
- redirect_fallthrough  out  1  predicted-taken branch resolved not-taken; fetch must load branch_pc+2
- flushed  out  1  squash cycle active
- forwarding_mask  out  2  forwarding enable mask
- mispredict_count  out  16  saturating event counter

Behaviour:
- Definitions:
  - mispredict = branch_valid & (branch_taken != branch_predicted).
  - uncond = is_j_in | is_jsr_in | is_trap_in.
  - event = (mispredict | uncond) & !stall.
  - With DYNAMIC=0 the prediction is always 0, so mispredict reduces to branch_valid & branch_taken.
- States:
  - IDLE: all gated outputs follow their inputs; flushed=0; forwarding_mask=11.
  - FLUSH: a 3-bit counter cnt runs 1..FLUSH_DEPTH. All gated outputs are 0, flushed=1 and redirect_fallthrough=0. forwarding_mask=00 when cnt==1, otherwise 11.
  - POST: outputs follow their inputs; forwarding_mask=10.
- Transitions:
  - IDLE: on event go to FLUSH with cnt=1; otherwise stay.
  - FLUSH: when stall=1, hold state and cnt. When stall=0 and cnt==FLUSH_DEPTH, go to POST; otherwise cnt+1.
  - POST: on event, go to FLUSH with cnt=1. Otherwise, if !stall, go to IDLE. If stall, hold.
  - Events presented during FLUSH are ignored; those instructions are being squashed.
- redirect_fallthrough = branch_valid & branch_predicted & !branch_taken & state!=FLUSH. It is combinational and asserts in the same cycle as the triggering event.
- Prediction:
  - Index is pc[BHT_INDEX_BITS:1]; PCs are word-aligned.
  - predict_taken = DYNAMIC ? bht[idx(fetch_pc)][1] : 0.
- BHT update (DYNAMIC=1 only):
  - Fires on posedge when branch_valid & !stall & state!=FLUSH.
  - Counter at idx(branch_pc) saturates up on taken and down on not-taken: 00↔01↔10↔11.
  - A same-cycle lookup of the index being updated returns the pre-update value.
- mispredict_count:
  - Increments on each posedge where event & mispredict.
  - Saturates at 0xFFFF.
  - Unconditional transfers do not count.
- Reset (including mid-flush):
  - State goes to IDLE, cnt=0, mispredict_count=0, and all BHT entries go to 01 (weakly not-taken).
  - Next cycle, outputs follow inputs and forwarding_mask=11.
- With FLUSH_DEPTH=3, DYNAMIC=0 and stall=0, cycle behaviour is identical to the existing fixed controller.

Test Plan:
- DYNAMIC=0, FLUSH_DEPTH=3: branch_valid=1, taken=1 for one cycle → flushed=1 for exactly 3 cycles, forwarding_mask 00,11,11, then 10 for one cycle, then IDLE; mispredict_count=1.
- stall=1 asserted during the 2nd flush cycle for 4 cycles → flushed stays 1 and cnt holds; total squash cycles with stall low = 3.
- DYNAMIC=1: branch at PC 0x3006 taken twice → counter 01→10→11. Then fetch_pc=0x3006 gives predict_taken=1. Branch presented with predicted=1, taken=1 → no flush, count unchanged.
- DYNAMIC=1: predicted=1, taken=0 → redirect_fallthrough=1 that cycle, flush starts, and the counter decrements 11→10.
- is_trap_in=1 in POST with stall=0 → re-enters FLUSH with cnt=1 and forwarding_mask=00; mispredict_count is unchanged.
- FLUSH_DEPTH=5: reset asserted at cnt=3 → IDLE next cycle, load_regfile_out follows its input, BHT entries read 01 (predict_taken=0), mispredict_count=0.
